// File: rtl/i2c_poll_sequencer.sv
// Sweeps a list of NUM_CH register addresses on one I2C device through the
// i2c_master command port and keeps the latest read per channel with valid flags.

module i2c_poll_slot #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_i,
    input  logic                  inv_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // A timed-out read keeps the stale value but drops its valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (wr_i) begin
            data_q  <= din_i;
            valid_q <= 1'b1;
        end else if (inv_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

module i2c_poll_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int REGISTER_WIDTH = 16,
    parameter int ADDRESS_WIDTH  = 15,
    parameter int POLL_PERIOD    = 50_000,
    parameter int TIMEOUT        = 1_000_000,
    localparam int CHW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             start,
    input  logic [ADDRESS_WIDTH-1:0]         device_addr,
    input  logic [NUM_CH*REGISTER_WIDTH-1:0] reg_addr_list,
    input  logic [15:0]                      divider,
    output logic                             m_enable,
    output logic                             m_read_write,
    output logic [REGISTER_WIDTH-1:0]        m_register_address,
    output logic [ADDRESS_WIDTH-1:0]         m_device_address,
    output logic [15:0]                      m_divider,
    input  logic                             m_busy,
    input  logic [DATA_WIDTH-1:0]            m_miso_data,
    output logic [NUM_CH*DATA_WIDTH-1:0]     data,
    output logic [NUM_CH-1:0]                valid,
    output logic                             update,
    output logic [CHW-1:0]                   ch_index,
    output logic                             sweep_done,
    output logic                             timeout_err
);
    localparam int TO_W  = $clog2(TIMEOUT) + 1;
    localparam int GAP_W = $clog2(POLL_PERIOD) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT_LOW, S_STORE, S_NEXT, S_GAP
    } state_t;

    state_t                                  state_q;
    logic [NUM_CH-1:0][REGISTER_WIDTH-1:0]   list_q;
    logic [TO_W-1:0]                         to_cnt_q;
    logic [GAP_W-1:0]                        gap_cnt_q;
    logic [CHW-1:0]                          ch_q;
    logic                                    m_enable_q;
    logic [REGISTER_WIDTH-1:0]               m_reg_q;
    logic [ADDRESS_WIDTH-1:0]                m_dev_q;
    logic [15:0]                             m_div_q;
    logic                                    update_q;
    logic                                    sweep_done_q;
    logic                                    timeout_err_q;

    logic [CHW-1:0] ch_d;
    logic           last_ch;
    logic           to_expire;
    logic           rd_done;
    logic           to_hit;

    assign ch_d      = ch_q + CHW'(1);
    assign last_ch   = (ch_q == CHW'(NUM_CH - 1));
    assign to_expire = (to_cnt_q == TO_W'(TIMEOUT - 1));
    // A read finishing on the timeout cycle still counts as good.
    assign rd_done   = (state_q == S_WAIT_LOW) && !m_busy;
    assign to_hit    = to_expire &&
                       ((state_q == S_ISSUE) || ((state_q == S_WAIT_LOW) && m_busy));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            list_q        <= '0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            ch_q          <= '0;
            m_enable_q    <= 1'b0;
            m_reg_q       <= '0;
            m_dev_q       <= '0;
            m_div_q       <= '0;
            update_q      <= 1'b0;
            sweep_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            update_q     <= 1'b0;
            sweep_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start || enable) begin
                        state_q <= S_LOAD;
                        if (start) timeout_err_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    list_q     <= reg_addr_list;
                    m_dev_q    <= device_addr;
                    m_div_q    <= divider;
                    m_reg_q    <= reg_addr_list[REGISTER_WIDTH-1:0];
                    ch_q       <= '0;
                    to_cnt_q   <= '0;
                    m_enable_q <= 1'b1;
                    state_q    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (to_hit) begin
                        m_enable_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                        sweep_done_q  <= last_ch;
                        state_q       <= S_NEXT;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                        if (m_busy) begin
                            m_enable_q <= 1'b0;
                            state_q    <= S_WAIT_LOW;
                        end
                    end
                end
                S_WAIT_LOW: begin
                    if (rd_done) begin
                        update_q <= 1'b1;
                        state_q  <= S_STORE;
                    end else if (to_hit) begin
                        timeout_err_q <= 1'b1;
                        sweep_done_q  <= last_ch;
                        state_q       <= S_NEXT;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_STORE: begin
                    sweep_done_q <= last_ch;
                    state_q      <= S_NEXT;
                end
                S_NEXT: begin
                    if (last_ch) begin
                        gap_cnt_q <= '0;
                        state_q   <= enable ? S_GAP : S_IDLE;
                    end else begin
                        ch_q       <= ch_d;
                        m_reg_q    <= list_q[ch_d];
                        to_cnt_q   <= '0;
                        m_enable_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_GAP: begin
                    if (start) begin
                        timeout_err_q <= 1'b0;
                        state_q       <= S_LOAD;
                    end else if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (gap_cnt_q == GAP_W'(POLL_PERIOD - 1)) begin
                        state_q <= S_LOAD;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_w;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        i2c_poll_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk    (clk),
            .reset  (reset),
            .wr_i   (rd_done && (ch_q == CHW'(k))),
            .inv_i  (to_hit && (ch_q == CHW'(k))),
            .din_i  (m_miso_data),
            .data_o (data_w[k]),
            .valid_o(valid[k])
        );
    end

    assign data               = data_w;
    assign m_enable           = m_enable_q;
    assign m_read_write       = 1'b1;
    assign m_register_address = m_reg_q;
    assign m_device_address   = m_dev_q;
    assign m_divider          = m_div_q;
    assign update             = update_q;
    assign ch_index           = ch_q;
    assign sweep_done         = sweep_done_q;
    assign timeout_err        = timeout_err_q;
endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Directed bench for i2c_poll_sequencer with a behavioural i2c_master stand-in
// that answers 0xA000+reg after 20 busy cycles unless the register is blocked.

module tb_i2c_poll_sequencer;
    localparam int NUM_CH = 4, DW = 16, RW = 16, AW = 15, PP = 100, TO = 50;

    logic                 clk = 1'b0, reset = 1'b0, enable = 1'b0, start = 1'b0;
    logic [AW-1:0]        device_addr = 15'h50;
    logic [NUM_CH*RW-1:0] reg_addr_list = {16'h13, 16'h12, 16'h11, 16'h10};
    logic [15:0]          divider = 16'h1234;
    logic                 m_enable, m_read_write, m_busy;
    logic [RW-1:0]        m_register_address;
    logic [AW-1:0]        m_device_address;
    logic [15:0]          m_divider;
    logic [DW-1:0]        m_miso_data;
    logic [NUM_CH*DW-1:0] data;
    logic [NUM_CH-1:0]    valid;
    logic                 update, sweep_done, timeout_err;
    logic [1:0]           ch_index;

    i2c_poll_sequencer #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .REGISTER_WIDTH(RW), .ADDRESS_WIDTH(AW),
        .POLL_PERIOD(PP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .device_addr(device_addr), .reg_addr_list(reg_addr_list), .divider(divider),
        .m_enable(m_enable), .m_read_write(m_read_write),
        .m_register_address(m_register_address), .m_device_address(m_device_address),
        .m_divider(m_divider), .m_busy(m_busy), .m_miso_data(m_miso_data),
        .data(data), .valid(valid), .update(update), .ch_index(ch_index),
        .sweep_done(sweep_done), .timeout_err(timeout_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // master stand-in
    logic          blk_en = 1'b0;
    logic [RW-1:0] blk_addr = '0;
    int            mb_cnt;
    logic [RW-1:0] mb_addr;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_miso_data <= '0; mb_cnt <= 0; mb_addr <= '0;
        end else if (mb_cnt != 0) begin
            mb_cnt <= mb_cnt - 1;
            if (mb_cnt == 1) begin
                m_busy      <= 1'b0;
                m_miso_data <= 16'hA000 + mb_addr;
            end
        end else if (m_enable && !(blk_en && m_register_address == blk_addr)) begin
            m_busy <= 1'b1; mb_cnt <= 20; mb_addr <= m_register_address;
        end
    end

    // event log, sampled mid-cycle
    int   rise_c[$], fall_c[$], bf_c[$], upd_c[$], sd_c[$];
    logic pen = 1'b0, pbusy = 1'b0;
    always @(negedge clk) begin
        if (m_enable && !pen) rise_c.push_back(cyc);
        if (!m_enable && pen) fall_c.push_back(cyc);
        if (!m_busy && pbusy) bf_c.push_back(cyc);
        if (update)           upd_c.push_back(cyc);
        if (sweep_done)       sd_c.push_back(cyc);
        pen   = m_enable;
        pbusy = m_busy;
    end

    int vecs = 0, miss = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_sd(input int n, input int lim, input string tag);
        int i = 0;
        while (sd_c.size() < n && i < lim) begin @(negedge clk); i++; end
        chk(tag, sd_c.size(), n);
    endtask

    task automatic wait_rise(input int n, input int lim, input string tag);
        int i = 0;
        while (rise_c.size() < n && i < lim) begin @(negedge clk); i++; end
        chk(tag, rise_c.size(), n);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    int r0, s0, u0, f0, b0;

    initial begin
        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_m_enable", m_enable, 0);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_update", update, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_ch_index", ch_index, 0);
        chk("rst_m_rw", m_read_write, 1);
        chk("rst_m_reg", m_register_address, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // single sweep, start ignored mid-sweep, list change deferred
        r0 = rise_c.size(); s0 = sd_c.size(); u0 = upd_c.size(); b0 = bf_c.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("lat_load_cycle", m_enable, 0);
        @(negedge clk);
        chk("lat_issue_cycle", m_enable, 1);
        chk("cmd_reg0", m_register_address, 16'h10);
        chk("cmd_dev", m_device_address, 15'h50);
        chk("cmd_div", m_divider, 16'h1234);
        reg_addr_list = {16'h23, 16'h22, 16'h21, 16'h20};
        device_addr   = 15'h33;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_sd(s0 + 1, 400, "single_sweep_done");
        chk("single_data", data, 64'hA013_A012_A011_A010);
        chk("single_valid", valid, 4'hF);
        chk("single_updates", upd_c.size() - u0, 4);
        chk("lat_update_after_fall", upd_c[u0] - bf_c[b0], 1);
        chk("lat_next_issue_after_fall", rise_c[r0 + 1] - bf_c[b0], 3);
        chk("single_last_reg", m_register_address, 16'h13);
        chk("single_dev_held", m_device_address, 15'h50);
        chk("single_ch_index", ch_index, 3);
        repeat (150) @(negedge clk);
        chk("single_txn_count", rise_c.size() - r0, 4);
        chk("single_sd_count", sd_c.size() - s0, 1);

        // continuous mode, then enable dropped mid-sweep
        r0 = rise_c.size(); s0 = sd_c.size();
        enable = 1'b1;
        wait_sd(s0 + 1, 400, "cont_sweep1");
        chk("cont_new_list", data[15:0], 16'hA020);
        chk("cont_new_dev", m_device_address, 15'h33);
        wait_rise(r0 + 5, 300, "cont_next_issue");
        chk("cont_gap", rise_c[r0 + 4] - sd_c[s0], 102);
        enable = 1'b0;
        wait_sd(s0 + 2, 400, "cont_sweep2");
        repeat (300) @(negedge clk);
        chk("cont_txn_count", rise_c.size() - r0, 8);
        chk("cont_sd_count", sd_c.size() - s0, 2);
        chk("cont_data", data, 64'hA023_A022_A021_A020);

        // timeout on channel 2
        blk_en = 1'b1; blk_addr = 16'h22;
        r0 = rise_c.size(); s0 = sd_c.size(); u0 = upd_c.size(); f0 = fall_c.size();
        pulse_start();
        wait_sd(s0 + 1, 600, "to_sweep_done");
        chk("to_enable_width", fall_c[f0 + 2] - rise_c[r0 + 2], 50);
        chk("to_valid", valid, 4'b1011);
        chk("to_err", timeout_err, 1);
        chk("to_data_kept", data[47:32], 16'hA022);
        chk("to_updates", upd_c.size() - u0, 3);
        chk("to_txn_count", rise_c.size() - r0, 4);
        repeat (5) @(negedge clk);
        blk_en = 1'b0;
        s0 = sd_c.size();
        pulse_start();
        chk("to_err_cleared", timeout_err, 0);
        wait_sd(s0 + 1, 400, "to_recover_sweep");
        chk("to_recover_valid", valid, 4'hF);

        // async reset in the middle of a transaction
        repeat (5) @(negedge clk);
        r0 = rise_c.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_rise(r0 + 1, 20, "rst_mid_rise");
        chk("rst_mid_en_before", m_enable, 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_en", m_enable, 0);
        chk("rst_mid_valid", valid, 0);
        chk("rst_mid_data", data, 0);
        @(negedge clk); reset = 1'b1;
        repeat (50) @(negedge clk);
        chk("rst_mid_no_txn", rise_c.size() - r0, 1);
        chk("rst_mid_idle_en", m_enable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
